// File: rtl/svf_multichannel.sv
// Time-multiplexed Chamberlin state-variable filter. A single multiplier serves
// CHANNELS channels. Each channel keeps its own lp/bp integrators and its own
// captured F, Q1 and mode. One sample_valid strobe starts a sweep of four
// cycles per channel (LP, HP, BP, OUT), followed by a DONE cycle.
//
// Handshake: sample_valid is a single-cycle strobe and is accepted only in IDLE.
// A strobe seen in any other state, including DONE, is dropped and pulses
// overrun on the following cycle. busy is high from the cycle after acceptance
// through the last OUT cycle. out_valid is high for exactly the DONE cycle, and
// by then every channel of out has been written.
module svf_multichannel #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 2,
  parameter int GUARD    = 4,
  parameter int CWIDTH   = 18
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [CHANNELS*BITSIZE-1:0]  in,
  input  logic [CHANNELS*CWIDTH-1:0]   F,
  input  logic [CHANNELS*CWIDTH-1:0]   Q1,
  input  logic [CHANNELS*2-1:0]        mode,
  output logic [CHANNELS*BITSIZE-1:0]  out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [2:0]                   dbg_state
);

  localparam int ACCW    = BITSIZE + GUARD;
  localparam int PW      = ACCW + CWIDTH + 1;
  localparam int SW      = PW + 2;
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int F_SHIFT = CWIDTH - 1;   // F is unsigned 1.17
  localparam int Q_SHIFT = CWIDTH - 2;   // Q1 is unsigned 2.16

  typedef enum logic [2:0] {IDLE, S_LP, S_HP, S_BP, S_OUT, DONE} state_t;

  state_t state, state_nxt;
  logic [CHW-1:0] ch;
  logic last_ch;

  logic [CHANNELS*BITSIZE-1:0] in_cap;
  logic [CHANNELS*CWIDTH-1:0]  f_cap, q_cap;
  logic [CHANNELS*2-1:0]       mode_cap;

  logic signed [ACCW-1:0] lp_q [CHANNELS];
  logic signed [ACCW-1:0] bp_q [CHANNELS];
  logic signed [ACCW-1:0] hp_q;

  logic [BITSIZE-1:0]      x_cur;
  logic [CWIDTH-1:0]       f_cur, q_cur;
  logic [1:0]              mode_cur;
  logic signed [ACCW-1:0]  lp_cur, bp_cur, x_ext, mul_src, acc_new;
  logic signed [PW-1:0]    coef_w, mul_w, prod, prod_f, prod_q;
  logic signed [SW-1:0]    acc_sum;
  logic signed [ACCW:0]    sel;
  logic [BITSIZE-1:0]      out_new;

  function automatic logic signed [SW-1:0] ext_acc(input logic signed [ACCW-1:0] v);
    ext_acc = {{(SW-ACCW){v[ACCW-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] ext_prod(input logic signed [PW-1:0] v);
    ext_prod = {{(SW-PW){v[PW-1]}}, v};
  endfunction

  // Clamp a wide sum into the integrator range without wrapping
  function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] hi, lo;
    hi = {{(SW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      sat_acc = hi[ACCW-1:0];
    else if (v < lo) sat_acc = lo[ACCW-1:0];
    else             sat_acc = v[ACCW-1:0];
  endfunction

  // Clamp a selected integrator value into the output sample range
  function automatic logic [BITSIZE-1:0] sat_out(input logic signed [ACCW:0] v);
    logic signed [ACCW:0] hi, lo;
    hi = {{(ACCW-BITSIZE+2){1'b0}}, {(BITSIZE-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      sat_out = hi[BITSIZE-1:0];
    else if (v < lo) sat_out = lo[BITSIZE-1:0];
    else             sat_out = v[BITSIZE-1:0];
  endfunction

  assign last_ch   = (ch == CHW'(CHANNELS - 1));
  assign dbg_state = state;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:  if (sample_valid) state_nxt = S_LP;
      S_LP:  begin busy = 1'b1; state_nxt = S_HP; end
      S_HP:  begin busy = 1'b1; state_nxt = S_BP; end
      S_BP:  begin busy = 1'b1; state_nxt = S_OUT; end
      S_OUT: begin busy = 1'b1; state_nxt = last_ch ? DONE : S_LP; end
      DONE:  begin out_valid = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared multiplier and the per-state integrator update
  always_comb begin
    x_cur    = in_cap[ch*BITSIZE +: BITSIZE];
    f_cur    = f_cap[ch*CWIDTH +: CWIDTH];
    q_cur    = q_cap[ch*CWIDTH +: CWIDTH];
    mode_cur = mode_cap[ch*2 +: 2];
    lp_cur   = lp_q[ch];
    bp_cur   = bp_q[ch];
    x_ext    = {{GUARD{x_cur[BITSIZE-1]}}, x_cur};
    coef_w   = {{(PW-CWIDTH){1'b0}}, (state == S_HP) ? q_cur : f_cur};
    mul_src  = (state == S_BP) ? hp_q : bp_cur;
    mul_w    = {{(PW-ACCW){mul_src[ACCW-1]}}, mul_src};
    prod     = coef_w * mul_w;
    prod_f   = prod >>> F_SHIFT;
    prod_q   = prod >>> Q_SHIFT;
    acc_sum  = '0;
    case (state)
      S_LP:    acc_sum = ext_acc(lp_cur) + ext_prod(prod_f);
      S_HP:    acc_sum = ext_acc(x_ext) - ext_acc(lp_cur) - ext_prod(prod_q);
      S_BP:    acc_sum = ext_acc(bp_cur) + ext_prod(prod_f);
      default: acc_sum = '0;
    endcase
    acc_new = sat_acc(acc_sum);
  end

  // Output selection: LP, HP, BP or notch (hp + lp)
  always_comb begin
    sel = '0;
    case (mode_cur)
      2'd0:    sel = {lp_cur[ACCW-1], lp_cur};
      2'd1:    sel = {hp_q[ACCW-1], hp_q};
      2'd2:    sel = {bp_cur[ACCW-1], bp_cur};
      default: sel = {lp_cur[ACCW-1], lp_cur} + {hp_q[ACCW-1], hp_q};
    endcase
    out_new = sat_out(sel);
  end

  // Capture the frame and its coefficients when a strobe is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cap   <= '0;
      f_cap    <= '0;
      q_cap    <= '0;
      mode_cap <= '0;
    end else if (state == IDLE && sample_valid) begin
      in_cap   <= in;
      f_cap    <= F;
      q_cap    <= Q1;
      mode_cap <= mode;
    end
  end

  // Channel index for the sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                ch <= '0;
    else if (state == IDLE)   ch <= '0;
    else if (state == S_OUT)  ch <= last_ch ? '0 : ch + CHW'(1);
  end

  // Integrator state; hp is only needed within one channel's slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        lp_q[i] <= '0;
        bp_q[i] <= '0;
      end
      hp_q <= '0;
    end else begin
      case (state)
        S_LP:    lp_q[ch] <= acc_new;
        S_HP:    hp_q     <= acc_new;
        S_BP:    bp_q[ch] <= acc_new;
        default: ;
      endcase
    end
  end

  // Output samples; unwritten channels keep their previous value
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                out <= '0;
    else if (state == S_OUT)  out[ch*BITSIZE +: BITSIZE] <= out_new;
  end

  // Overrun pulse for a strobe that arrives outside IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= sample_valid && (state != IDLE);
  end

endmodule

// File: tb/tb_svf_multichannel.sv
// Directed bench for svf_multichannel with two channels. Expected sample values
// are worked out by hand from the filter recurrences.
module tb_svf_multichannel;

  localparam int BITSIZE  = 16;
  localparam int CHANNELS = 2;
  localparam int CWIDTH   = 18;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         sample_valid;
  logic [CHANNELS*BITSIZE-1:0]  in;
  logic [CHANNELS*CWIDTH-1:0]   F;
  logic [CHANNELS*CWIDTH-1:0]   Q1;
  logic [CHANNELS*2-1:0]        mode;
  logic [CHANNELS*BITSIZE-1:0]  out;
  logic                         out_valid;
  logic                         busy;
  logic                         overrun;
  logic [2:0]                   dbg_state;

  int tests = 0;
  int fails = 0;

  svf_multichannel #(
    .BITSIZE(BITSIZE), .CHANNELS(CHANNELS), .GUARD(4), .CWIDTH(CWIDTH)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .in(in),
    .F(F), .Q1(Q1), .mode(mode), .out(out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ch_out(input int c);
    logic signed [BITSIZE-1:0] v;
    v = out[c*BITSIZE +: BITSIZE];
    return int'(v);
  endfunction

  task automatic set_ch(input int c, input int x, input int f, input int q, input int m);
    in[c*BITSIZE +: BITSIZE] = x[BITSIZE-1:0];
    F[c*CWIDTH +: CWIDTH]    = f[CWIDTH-1:0];
    Q1[c*CWIDTH +: CWIDTH]   = q[CWIDTH-1:0];
    mode[c*2 +: 2]           = m[1:0];
  endtask

  // Strobe one frame, wait (bounded) for out_valid, then return to IDLE
  task automatic run_frame;
    int n;
    sample_valid = 1'b1;
    step;
    sample_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    chk("frame_out_valid", int'(out_valid), 1);
    step;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
    step;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    sample_valid = 1'b0;
    in = '0;
    F = '0;
    Q1 = '0;
    mode = '0;
    step;
    step;
    chk("rst_out0", ch_out(0), 0);
    chk("rst_out1", ch_out(1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    step;

    // ch0: x=1000, F=0.5, Q1=1.0, LP   ch1: x=-2000, F=1.0, Q1=0.5, HP
    set_ch(0, 1000, 65536, 65536, 0);
    set_ch(1, -2000, 131072, 32768, 1);

    // Frame 1: handshake timing, strobe at t
    sample_valid = 1'b1;
    step;
    sample_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("f1_busy_t%0d", k), int'(busy), 1);
      chk($sformatf("f1_nvalid_t%0d", k), int'(out_valid), 0);
      step;
    end
    chk("f1_out_valid_t9", int'(out_valid), 1);
    chk("f1_busy_t9", int'(busy), 0);
    chk("f1_out0", ch_out(0), 0);
    chk("f1_out1", ch_out(1), -2000);
    step;
    chk("f1_out_valid_t10", int'(out_valid), 0);
    chk("f1_busy_t10", int'(busy), 0);

    // Frame 2: ch0 written at t+5 while ch1 keeps the previous frame
    sample_valid = 1'b1;
    step;
    sample_valid = 1'b0;
    repeat (4) step;
    chk("f2_mid_out0", ch_out(0), 250);
    chk("f2_mid_out1", ch_out(1), -2000);
    repeat (4) step;
    chk("f2_out_valid", int'(out_valid), 1);
    chk("f2_out0", ch_out(0), 250);
    chk("f2_out1", ch_out(1), 1000);
    step;

    // Frame 3: extra strobe at t+3 and another in the DONE cycle, both dropped
    sample_valid = 1'b1;
    step;
    sample_valid = 1'b0;
    step;
    step;
    sample_valid = 1'b1;
    set_ch(0, 30000, 65536, 65536, 0);
    step;
    chk("f3_overrun_t4", int'(overrun), 1);
    chk("f3_busy_t4", int'(busy), 1);
    sample_valid = 1'b0;
    set_ch(0, 1000, 65536, 65536, 0);
    step;
    chk("f3_overrun_t5", int'(overrun), 0);
    repeat (4) step;
    chk("f3_out_valid", int'(out_valid), 1);
    chk("f3_out0", ch_out(0), 562);
    chk("f3_out1", ch_out(1), 1500);
    sample_valid = 1'b1;
    step;
    chk("done_overrun", int'(overrun), 1);
    chk("done_busy", int'(busy), 0);
    sample_valid = 1'b0;
    step;
    chk("done_dropped_busy", int'(busy), 0);
    chk("done_dropped_out0", ch_out(0), 562);

    // Frame 4: BP on ch0, notch on ch1; mode changes mid-sweep are ignored
    mode = {2'd3, 2'd2};
    sample_valid = 1'b1;
    step;
    sample_valid = 1'b0;
    mode = '0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      step;
      cnt++;
    end
    chk("f4_out_valid", int'(out_valid), 1);
    chk("f4_bp_out0", ch_out(0), 352);
    chk("f4_notch_out1", ch_out(1), -2250);
    step;

    // Reset in the middle of a sweep
    sample_valid = 1'b1;
    step;
    sample_valid = 1'b0;
    step;
    step;
    reset = 1'b1;
    #1;
    chk("midrst_out0", ch_out(0), 0);
    chk("midrst_out1", ch_out(1), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    step;
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin
      step;
      if (out_valid === 1'b1) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);
    set_ch(0, 1000, 65536, 65536, 1);
    set_ch(1, -2000, 131072, 32768, 1);
    run_frame;
    chk("postrst_out0", ch_out(0), 1000);
    chk("postrst_out1", ch_out(1), -2000);

    // Saturation: full-scale inputs, undamped, F=0.5, LP
    pulse_reset;
    set_ch(0, -32768, 65536, 0, 0);
    set_ch(1, 32767, 65536, 0, 0);
    run_frame;
    run_frame;
    run_frame;
    chk("sat_f3_out0", ch_out(0), -22528);
    chk("sat_f3_out1", ch_out(1), 22526);
    run_frame;
    chk("sat_f4_out0", ch_out(0), -32768);
    chk("sat_f4_out1", ch_out(1), 32767);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
